// File: rtl/mano_mem_arbiter.sv
// Two-port arbiter in front of the single Mano main memory: grants one requester,
// runs a fixed-latency strobe cycle, and returns a one-cycle ack with read data.
module mano_mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1,
  parameter int RR_EN   = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic              last, last_d;
  logic              we_q, we_d;
  logic              win;
  logic              gid_d, rd_d, wr_d, ack0_d, ack1_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dout_d, rdata0_d, rdata1_d;

  assign busy = (state != IDLE);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    last_d   = last;
    we_d     = we_q;
    win      = 1'b0;
    gid_d    = grant_id;
    rd_d     = mem_rd;
    wr_d     = mem_wr;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    addr_d   = mem_addr;
    dout_d   = mem_dout;
    rdata0_d = r0_rdata;
    rdata1_d = r1_rdata;
    unique case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          // On conflict the round-robin pointer hands the grant to the port that did not win last.
          if (r0_req && r1_req) win = (RR_EN != 0) && !last;
          else                  win = r1_req;
          gid_d   = win;
          last_d  = win;
          we_d    = win ? r1_we    : r0_we;
          addr_d  = win ? r1_addr  : r0_addr;
          dout_d  = win ? r1_wdata : r0_wdata;
          rd_d    = ~we_d;
          wr_d    = we_d;
          cnt_d   = LAT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt - 4'd1;
        if (cnt == 4'd1) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (!we_q) begin
            if (grant_id) rdata1_d = mem_din;
            else          rdata0_d = mem_din;
          end
          ack0_d  = ~grant_id;
          ack1_d  = grant_id;
          state_d = DONE;
        end
      end
      DONE: begin
        gid_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      last     <= 1'b1;
      we_q     <= 1'b0;
      grant_id <= 1'b0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      mem_addr <= '0;
      mem_dout <= '0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      last     <= last_d;
      we_q     <= we_d;
      grant_id <= gid_d;
      mem_rd   <= rd_d;
      mem_wr   <= wr_d;
      r0_ack   <= ack0_d;
      r1_ack   <= ack1_d;
      mem_addr <= addr_d;
      mem_dout <= dout_d;
      r0_rdata <= rdata0_d;
      r1_rdata <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_mano_mem_arbiter.sv
// Bench for mano_mem_arbiter: four instances with different latency / arbitration
// settings, each backed by its own 4096x16 memory, checked by directed tables and a reference memory.
module tb_mano_mem_arbiter;

  localparam int NI = 4;
  localparam int LATS [0:NI-1] = '{1, 3, 2, 15};
  localparam int RRS  [0:NI-1] = '{1, 1, 0, 1};

  logic clk, clr, mem_clr;
  logic        r0_req [NI], r0_we [NI], r0_ack [NI];
  logic        r1_req [NI], r1_we [NI], r1_ack [NI];
  logic [11:0] r0_addr [NI], r1_addr [NI], mem_addr [NI];
  logic [15:0] r0_wdata [NI], r1_wdata [NI], r0_rdata [NI], r1_rdata [NI];
  logic [15:0] mem_dout [NI], mem_din [NI];
  logic        mem_rd [NI], mem_wr [NI], busy [NI], grant_id [NI];

  logic [15:0] mem     [NI][4096];
  logic [15:0] ref_mem [NI][4096];

  int n_pass, n_tot, viol;
  int slen [NI];

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    mano_mem_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(LATS[g]), .RR_EN(RRS[g])) u_dut (
      .clk(clk), .clr(clr),
      .r0_req(r0_req[g]), .r0_we(r0_we[g]), .r0_addr(r0_addr[g]), .r0_wdata(r0_wdata[g]),
      .r0_ack(r0_ack[g]), .r0_rdata(r0_rdata[g]),
      .r1_req(r1_req[g]), .r1_we(r1_we[g]), .r1_addr(r1_addr[g]), .r1_wdata(r1_wdata[g]),
      .r1_ack(r1_ack[g]), .r1_rdata(r1_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]),
      .mem_dout(mem_dout[g]), .mem_din(mem_din[g]),
      .busy(busy[g]), .grant_id(grant_id[g])
    );
    assign mem_din[g] = mem[g][mem_addr[g]];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (mem_clr) begin
        for (int i = 0; i < 4096; i++) mem[g][i] <= (i == 12'h0A5) ? 16'hBEEF : 16'h0000;
      end else if (mem_wr[g]) begin
        mem[g][mem_addr[g]] <= mem_dout[g];
      end
    end
  end

  // Protocol watch: strobe overlap, double ack, strobe run length.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (clr) begin
        if (mem_rd[g] && mem_wr[g]) viol <= viol + 1;
        if (r0_ack[g] && r1_ack[g]) viol <= viol + 1;
        if (mem_rd[g] || mem_wr[g]) slen[g] <= slen[g] + 1;
        else begin
          if (slen[g] != 0 && slen[g] != LATS[g]) viol <= viol + 1;
          slen[g] <= 0;
        end
      end else begin
        slen[g] <= 0;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete access from IDLE; returns latency in edges (-1 on timeout).
  task automatic do_access(input int inst, input bit port, input bit we,
                           input logic [11:0] addr, input logic [15:0] wdata,
                           output logic [15:0] rdata, output int lat, output bit strobe_ok);
    int sc;
    bit got, ack_me, ack_other;
    sc = 0; got = 0; lat = 0; strobe_ok = 1; rdata = 16'h0;
    if (port) begin
      r1_req[inst] = 1; r1_we[inst] = we; r1_addr[inst] = addr; r1_wdata[inst] = wdata;
    end else begin
      r0_req[inst] = 1; r0_we[inst] = we; r0_addr[inst] = addr; r0_wdata[inst] = wdata;
    end
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (mem_rd[inst] || mem_wr[inst]) begin
        sc++;
        if (mem_addr[inst] != addr || mem_wr[inst] != we || mem_rd[inst] == we ||
            (we && mem_dout[inst] != wdata)) strobe_ok = 0;
      end
      ack_me    = port ? r1_ack[inst] : r0_ack[inst];
      ack_other = port ? r0_ack[inst] : r1_ack[inst];
      if (ack_other) strobe_ok = 0;
      if (ack_me) begin
        got = 1;
        rdata = port ? r1_rdata[inst] : r0_rdata[inst];
      end
    end
    r0_req[inst] = 0;
    r1_req[inst] = 0;
    if (sc != LATS[inst]) strobe_ok = 0;
    if (!got) lat = -1;
    if (we) ref_mem[inst][addr] = wdata;
    tick();
  endtask

  // Both ports request continuously; records the order of the first four acks.
  task automatic contend(input int inst);
    int n, cyc, last_cyc;
    bit ports [4];
    n = 0; cyc = 0; last_cyc = 0;
    r0_req[inst] = 1; r0_we[inst] = 0; r0_addr[inst] = 12'h001;
    r1_req[inst] = 1; r1_we[inst] = 0; r1_addr[inst] = 12'h002;
    while (n < 4 && cyc < 200) begin
      tick();
      cyc++;
      if (r0_ack[inst] || r1_ack[inst]) begin
        ports[n] = r1_ack[inst];
        if (n == 0) chk("contend_first_latency", cyc, LATS[inst] + 1);
        else        chk("contend_ack_spacing", cyc - last_cyc, LATS[inst] + 2);
        last_cyc = cyc;
        n++;
        if (n == 4) begin
          r0_req[inst] = 0;
          r1_req[inst] = 0;
        end
      end
    end
    r0_req[inst] = 0;
    r1_req[inst] = 0;
    chk("contend_ack_count", n, 4);
    for (int i = 0; i < n; i++)
      chk(RRS[inst] != 0 ? "contend_rr_grant" : "contend_fixed_grant", ports[i],
          (RRS[inst] != 0) ? (i % 2) : 0);
    tick();
  endtask

  typedef struct {
    int          inst;
    bit          port;
    bit          we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [15:0] rd, exp;
    int lat, bad, busy_cnt, waited;
    bit sok, got0, got1;
    int inst;
    bit port, we;
    logic [11:0] addr;
    logic [15:0] wdata;

    n_pass = 0; n_tot = 0; viol = 0;
    for (int g = 0; g < NI; g++) begin
      r0_req[g] = 0; r0_we[g] = 0; r0_addr[g] = '0; r0_wdata[g] = '0;
      r1_req[g] = 0; r1_we[g] = 0; r1_addr[g] = '0; r1_wdata[g] = '0;
      slen[g] = 0;
      for (int i = 0; i < 4096; i++) ref_mem[g][i] = (i == 12'h0A5) ? 16'hBEEF : 16'h0000;
    end

    vecs[0]  = '{0, 1'b0, 1'b0, 12'h0A5, 16'h0000, 16'hBEEF};
    vecs[1]  = '{1, 1'b1, 1'b1, 12'hFFF, 16'h1234, 16'h0000};
    vecs[2]  = '{1, 1'b1, 1'b0, 12'hFFF, 16'h0000, 16'h1234};
    vecs[3]  = '{1, 1'b1, 1'b1, 12'hFFF, 16'h5678, 16'h1234};
    vecs[4]  = '{1, 1'b0, 1'b0, 12'hFFF, 16'h0000, 16'h5678};
    vecs[5]  = '{0, 1'b1, 1'b1, 12'h010, 16'hAAAA, 16'h0000};
    vecs[6]  = '{0, 1'b0, 1'b0, 12'h010, 16'h0000, 16'hAAAA};
    vecs[7]  = '{0, 1'b1, 1'b0, 12'h0A5, 16'h0000, 16'hBEEF};
    vecs[8]  = '{3, 1'b0, 1'b1, 12'h000, 16'hFFFF, 16'h0000};
    vecs[9]  = '{3, 1'b0, 1'b0, 12'h000, 16'h0000, 16'hFFFF};
    vecs[10] = '{2, 1'b0, 1'b1, 12'h123, 16'h0F0F, 16'h0000};
    vecs[11] = '{2, 1'b1, 1'b0, 12'h123, 16'h0000, 16'h0F0F};

    // Power-on reset
    clr = 0;
    mem_clr = 1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("reset_ctrl", {busy[g], mem_rd[g], mem_wr[g], r0_ack[g], r1_ack[g], grant_id[g]}, 0);
      chk("reset_data", {mem_addr[g], mem_dout[g], r0_rdata[g], r1_rdata[g]}, 0);
    end
    mem_clr = 0;
    clr = 1;
    tick();

    // Directed table
    for (int i = 0; i < 12; i++) begin
      do_access(vecs[i].inst, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, sok);
      chk("table_rdata", rd, vecs[i].exp_rdata);
      chk("table_latency", lat, LATS[vecs[i].inst] + 1);
      chk("table_strobes", sok, 1);
    end

    // Reset in the middle of a 15-cycle read
    r0_req[3] = 1; r0_we[3] = 0; r0_addr[3] = 12'h005;
    repeat (3) tick();
    chk("rst_mid_rd_before", mem_rd[3], 1);
    clr = 0;
    r1_req[3] = 1; r1_we[3] = 0; r1_addr[3] = 12'h006;
    #1;
    chk("rst_mid_async_ctrl", {mem_rd[3], mem_wr[3], busy[3], r0_ack[3], r1_ack[3]}, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_held_idle", busy[3], 0);
    clr = 1;
    tick();
    chk("rst_first_grant_busy", busy[3], 1);
    chk("rst_first_grant_port", grant_id[3], 0);
    r0_req[3] = 0;
    r1_req[3] = 0;
    got0 = 0; got1 = 0; waited = 0;
    while (busy[3] && waited < 40) begin
      tick();
      waited++;
      if (r0_ack[3]) got0 = 1;
      if (r1_ack[3]) got1 = 1;
    end
    chk("rst_drain_done", busy[3], 0);
    chk("req_drop_still_acked", got0, 1);
    chk("req_drop_no_other_ack", got1, 0);

    // Contention, both arbitration modes
    contend(0);
    contend(2);

    // Address change while the access is in flight
    r0_req[1] = 1; r0_we[1] = 0; r0_addr[1] = 12'h0A5;
    bad = 0; got0 = 0; waited = 0; rd = 0;
    while (!got0 && waited < 40) begin
      tick();
      waited++;
      if (waited == 1) r0_addr[1] = 12'h777;
      if ((mem_rd[1] || mem_wr[1]) && mem_addr[1] != 12'h0A5) bad++;
      if (r0_ack[1]) begin
        got0 = 1;
        rd = r0_rdata[1];
        r0_req[1] = 0;
      end
    end
    chk("stab_mem_addr", bad, 0);
    chk("stab_ack", got0, 1);
    chk("stab_rdata", rd, 16'hBEEF);
    busy_cnt = 0;
    repeat (6) begin
      tick();
      if (busy[1]) busy_cnt++;
    end
    chk("stab_no_reaccess", busy_cnt, 0);
    r0_addr[1] = 12'h000;

    // Random traffic against the reference memory
    for (int k = 0; k < 1000; k++) begin
      inst  = k % NI;
      port  = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = 12'($urandom_range(0, 31));
      wdata = 16'($urandom);
      exp   = ref_mem[inst][addr];
      do_access(inst, port, we, addr, wdata, rd, lat, sok);
      if (!we) chk("rand_rdata", rd, exp);
      chk("rand_latency", lat, LATS[inst] + 1);
      chk("rand_strobes", sok, 1);
    end

    tick();
    chk("protocol_violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
